// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter sequencer: FSM states, command opcodes and window modes.
package counter_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN_UP = 3'd2,
    ST_RUN_DN = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [1:0] CMD_START  = 2'b00;
  localparam logic [1:0] CMD_STOP   = 2'b01;
  localparam logic [1:0] CMD_PAUSE  = 2'b10;
  localparam logic [1:0] CMD_RESUME = 2'b11;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_BOUNCE   = 2'b10;
  localparam logic [1:0] MODE_RSVD     = 2'b11;

  function automatic logic state_busy(input state_e s);
    return (s == ST_CLEAR) || (s == ST_RUN_UP) || (s == ST_RUN_DN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/counter_seq_ctrl.sv
// Sequencer for an external up/down counter: runs one-shot, periodic or bounce windows
// of 0..limit under host START/STOP/PAUSE/RESUME commands and flags terminal events.
module counter_seq_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_up,
  output logic             cnt_hold,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done_pulse,
  output logic             wrap_pulse,
  output logic             err_pulse
);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             up_q, up_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic cmd_acc;
  logic at_limit;
  logic at_zero;
  logic freeze;

  assign cmd_ready = (state_q != ST_CLEAR);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign at_limit  = (cnt_val == limit_q);
  assign at_zero   = (cnt_val == '0);
  // STOP/PAUSE must stop the count in the very cycle they are accepted.
  assign freeze    = cmd_acc && ((cmd_op == CMD_STOP) || (cmd_op == CMD_PAUSE));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    up_d    = up_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cmd_acc) begin
          case (cmd_op)
            CMD_START: begin
              mode_d  = cfg_mode;
              limit_d = cfg_limit;
              if (cfg_mode == MODE_RSVD) err_d = 1'b1;
              else                       state_d = ST_CLEAR;
            end
            CMD_STOP: state_d = ST_IDLE;
            default:  err_d = 1'b1;
          endcase
        end
      end
      ST_CLEAR: begin
        state_d = ST_RUN_UP;
        up_d    = 1'b1;
      end
      ST_RUN_UP: begin
        if (cmd_acc) begin
          case (cmd_op)
            CMD_STOP:  state_d = ST_IDLE;
            CMD_PAUSE: begin
              dir_d   = 1'b1;
              state_d = ST_PAUSE;
            end
            default:   err_d = 1'b1;
          endcase
        end else if (at_limit) begin
          case (mode_q)
            MODE_ONESHOT: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
            MODE_PERIODIC: begin
              state_d = ST_CLEAR;
              wrap_d  = 1'b1;
            end
            MODE_BOUNCE: begin
              state_d = ST_RUN_DN;
              up_d    = 1'b0;
              wrap_d  = 1'b1;
            end
            default: state_d = ST_RUN_UP;
          endcase
        end
      end
      ST_RUN_DN: begin
        if (cmd_acc) begin
          case (cmd_op)
            CMD_STOP:  state_d = ST_IDLE;
            CMD_PAUSE: begin
              dir_d   = 1'b0;
              state_d = ST_PAUSE;
            end
            default:   err_d = 1'b1;
          endcase
        end else if (at_zero && (mode_q == MODE_BOUNCE)) begin
          state_d = ST_RUN_UP;
          up_d    = 1'b1;
          wrap_d  = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (cmd_acc) begin
          case (cmd_op)
            CMD_RESUME: begin
              state_d = dir_q ? ST_RUN_UP : ST_RUN_DN;
              up_d    = dir_q;
            end
            CMD_STOP: state_d = ST_IDLE;
            default:  err_d = 1'b1;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      limit_q <= '0;
      dir_q   <= 1'b1;
      up_q    <= 1'b1;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
      up_q    <= up_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cnt_hold = 1'b1;
    case (state_q)
      ST_RUN_UP: cnt_hold = at_limit || freeze;
      ST_RUN_DN: cnt_hold = at_zero || freeze;
      default:   cnt_hold = 1'b1;
    endcase
  end

  assign cnt_up     = up_q;
  assign cnt_clr    = (state_q == ST_CLEAR);
  assign busy       = state_busy(state_q);
  assign done_pulse = done_q;
  assign wrap_pulse = wrap_q;
  assign err_pulse  = err_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl driving a behavioural 32-bit up/down counter.
module tb_counter_seq_ctrl;

  localparam int W = 32;
  localparam logic [1:0] OP_START = 2'b00, OP_STOP = 2'b01, OP_PAUSE = 2'b10, OP_RESUME = 2'b11;
  localparam logic [1:0] M_ONE = 2'b00, M_PER = 2'b01, M_BNC = 2'b10, M_RSV = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [1:0]   cfg_mode;
  logic [W-1:0] cfg_limit;
  logic [W-1:0] cnt_val = '0;
  logic         cnt_up, cnt_hold, cnt_clr, busy, done_pulse, wrap_pulse, err_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cfg_mode(cfg_mode), .cfg_limit(cfg_limit), .cnt_val(cnt_val),
    .cnt_up(cnt_up), .cnt_hold(cnt_hold), .cnt_clr(cnt_clr), .busy(busy),
    .done_pulse(done_pulse), .wrap_pulse(wrap_pulse), .err_pulse(err_pulse)
  );

  // External counter: synchronous clear, otherwise steps unless held; not touched by rst_n.
  always @(posedge clk) begin
    if (cnt_clr)        cnt_val <= '0;
    else if (!cnt_hold) cnt_val <= cnt_up ? cnt_val + 1 : cnt_val - 1;
  end

  typedef struct {
    int cnt; bit cnt_vld; bit up; bit up_vld;
    bit clr; bit busy; bit done; bit wrap; bit hold;
  } exp_t;

  // Expected outputs t cycles after an accepted START, derived from the window rules.
  function automatic exp_t model(input int mode, input int lim, input int t);
    exp_t e;
    int p, u, m, q;
    e = '{cnt: 0, cnt_vld: (t > 0), up: 1, up_vld: (t > 0),
          clr: 0, busy: 1, done: 0, wrap: 0, hold: 1};
    if (t == 0) begin
      e.clr = 1;
      return e;
    end
    case (mode)
      0: begin
        if (t <= lim + 1) begin
          e.cnt = t - 1; e.hold = (t == lim + 1);
        end else begin
          e.cnt = lim; e.busy = 0; e.done = (t == lim + 2);
        end
      end
      1: begin
        p = t % (lim + 2);
        if (p == 0) begin
          e.clr = 1; e.cnt = lim; e.wrap = 1;
        end else begin
          e.cnt = p - 1; e.hold = (p == lim + 1);
        end
      end
      default: begin
        u = t - 1; m = 2 * lim + 2; q = u % m;
        e.up   = (q <= lim);
        e.cnt  = e.up ? q : m - 1 - q;
        e.hold = (q == lim) || (q == m - 1);
        e.wrap = (u > 0) && ((q == lim + 1) || (q == 0));
      end
    endcase
    return e;
  endfunction

  // Drive one command for a single cycle starting at a falling edge; returns at the next one.
  task automatic send(input logic [1:0] op, input logic [1:0] mode, input logic [W-1:0] lim);
    cmd_valid = 1'b1; cmd_op = op; cfg_mode = mode; cfg_limit = lim;
    @(negedge clk);
    cmd_valid = 1'b0;
    cfg_mode  = 2'($urandom_range(0, 3));
    cfg_limit = W'($urandom);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_START; cfg_mode = M_ONE; cfg_limit = '0;
    repeat (3) @(negedge clk);
    n_checks++; if ({cnt_up, cnt_hold, cnt_clr, busy} !== 4'b1100)
      $display("FAIL reset_ctl up/hold/clr/busy=%b want 1100", {cnt_up, cnt_hold, cnt_clr, busy}); else n_pass++;
    n_checks++; if ({done_pulse, wrap_pulse, err_pulse, cmd_ready} !== 4'b0001)
      $display("FAIL reset_pulses done/wrap/err/ready=%b want 0001", {done_pulse, wrap_pulse, err_pulse, cmd_ready}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_oneshot;
    int exp_c[8] = '{0, 1, 2, 3, 4, 5, 5, 5};
    send(OP_START, M_ONE, 5);
    n_checks++; if ({cnt_clr, cmd_ready, busy} !== 3'b101)
      $display("FAIL oneshot_clear clr/ready/busy=%b want 101", {cnt_clr, cmd_ready, busy}); else n_pass++;
    @(negedge clk);
    for (int t = 1; t <= 8; t++) begin
      n_checks++; if (cnt_val !== W'(exp_c[t-1]))
        $display("FAIL oneshot_cnt t=%0d got %0d want %0d", t, cnt_val, exp_c[t-1]); else n_pass++;
      n_checks++; if (done_pulse !== (t == 7) || busy !== (t < 7))
        $display("FAIL oneshot_flags t=%0d done=%b busy=%b want %b %b", t, done_pulse, busy, t == 7, t < 7); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_periodic;
    int exp_c[11] = '{0, 1, 2, 3, 3, 0, 1, 2, 3, 3, 0};
    send(OP_START, M_PER, 3);
    @(negedge clk);
    for (int t = 1; t <= 11; t++) begin
      n_checks++; if (cnt_val !== W'(exp_c[t-1]))
        $display("FAIL periodic_cnt t=%0d got %0d want %0d", t, cnt_val, exp_c[t-1]); else n_pass++;
      n_checks++; if (wrap_pulse !== (t == 5 || t == 10) || cnt_clr !== (t == 5 || t == 10))
        $display("FAIL periodic_wrap t=%0d wrap=%b clr=%b", t, wrap_pulse, cnt_clr); else n_pass++;
      @(negedge clk);
    end
    send(OP_STOP, M_ONE, 0);
  endtask

  task automatic test_bounce;
    int exp_c[8] = '{0, 1, 2, 2, 1, 0, 0, 1};
    bit exp_u[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    send(OP_START, M_BNC, 2);
    @(negedge clk);
    for (int t = 1; t <= 8; t++) begin
      n_checks++; if (cnt_val !== W'(exp_c[t-1]) || cnt_up !== exp_u[t-1])
        $display("FAIL bounce_cnt t=%0d got %0d/%b want %0d/%b", t, cnt_val, cnt_up, exp_c[t-1], exp_u[t-1]); else n_pass++;
      n_checks++; if (wrap_pulse !== (t == 4 || t == 7))
        $display("FAIL bounce_wrap t=%0d got %b want %b", t, wrap_pulse, t == 4 || t == 7); else n_pass++;
      @(negedge clk);
    end
    send(OP_STOP, M_ONE, 0);
  endtask

  task automatic test_pause;
    send(OP_START, M_ONE, 20);
    @(negedge clk);
    for (int k = 0; k < 64 && cnt_val !== 7; k++) @(negedge clk);
    n_checks++; if (cnt_val !== 7) $display("FAIL pause_reach7 got %0d want 7", cnt_val); else n_pass++;
    send(OP_PAUSE, M_ONE, 0);
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (cnt_val !== 7 || cnt_hold !== 1'b1 || busy !== 1'b1)
        $display("FAIL pause_frozen k=%0d cnt=%0d hold=%b busy=%b want 7 1 1", k, cnt_val, cnt_hold, busy); else n_pass++;
      @(negedge clk);
    end
    send(OP_RESUME, M_ONE, 0);
    @(negedge clk);
    n_checks++; if (cnt_val !== 8 || cnt_up !== 1'b1) $display("FAIL resume_8 got %0d/%b want 8/1", cnt_val, cnt_up); else n_pass++;
    @(negedge clk);
    n_checks++; if (cnt_val !== 9) $display("FAIL resume_9 got %0d want 9", cnt_val); else n_pass++;
    send(OP_STOP, M_ONE, 0);
    send(OP_START, M_BNC, 4);
    @(negedge clk);
    for (int k = 0; k < 64 && !(cnt_val === 2 && cnt_up === 1'b0); k++) @(negedge clk);
    n_checks++; if (cnt_val !== 2 || cnt_up !== 1'b0) $display("FAIL pause_dn_reach got %0d/%b want 2/0", cnt_val, cnt_up); else n_pass++;
    send(OP_PAUSE, M_ONE, 0);
    repeat (3) @(negedge clk);
    send(OP_RESUME, M_ONE, 0);
    @(negedge clk);
    n_checks++; if (cnt_val !== 1 || cnt_up !== 1'b0) $display("FAIL resume_dn got %0d/%b want 1/0", cnt_val, cnt_up); else n_pass++;
    send(OP_STOP, M_ONE, 0);
  endtask

  task automatic test_same_cycle;
    send(OP_START, M_ONE, 3);
    @(negedge clk);
    for (int k = 0; k < 32 && cnt_val !== 3; k++) @(negedge clk);
    send(OP_PAUSE, M_ONE, 0);
    n_checks++; if (done_pulse !== 1'b0 || busy !== 1'b1 || cnt_val !== 3)
      $display("FAIL cmd_beats_term done=%b busy=%b cnt=%0d want 0 1 3", done_pulse, busy, cnt_val); else n_pass++;
    send(OP_RESUME, M_ONE, 0);
    n_checks++; if (done_pulse !== 1'b0 || busy !== 1'b1 || cnt_hold !== 1'b1)
      $display("FAIL resume_at_limit done=%b busy=%b hold=%b want 0 1 1", done_pulse, busy, cnt_hold); else n_pass++;
    @(negedge clk);
    n_checks++; if (done_pulse !== 1'b1 || busy !== 1'b0)
      $display("FAIL resume_term done=%b busy=%b want 1 0", done_pulse, busy); else n_pass++;
  endtask

  task automatic test_errors;
    logic [W-1:0] c;
    send(OP_START, M_PER, 10);
    repeat (3) @(negedge clk);
    c = cnt_val;
    send(OP_START, M_ONE, 1);
    n_checks++; if (err_pulse !== 1'b1 || busy !== 1'b1 || cnt_val !== c + 1)
      $display("FAIL err_start_run err=%b busy=%b cnt=%0d want 1 1 %0d", err_pulse, busy, cnt_val, c + 1); else n_pass++;
    @(negedge clk);
    n_checks++; if (err_pulse !== 1'b0 || cnt_val !== c + 2)
      $display("FAIL err_one_cycle err=%b cnt=%0d want 0 %0d", err_pulse, cnt_val, c + 2); else n_pass++;
    c = cnt_val;
    send(OP_STOP, M_ONE, 0);
    n_checks++; if (busy !== 1'b0 || cnt_val !== c || err_pulse !== 1'b0)
      $display("FAIL stop_freeze busy=%b cnt=%0d err=%b want 0 %0d 0", busy, cnt_val, err_pulse, c); else n_pass++;
    send(OP_RESUME, M_ONE, 0);
    n_checks++; if (err_pulse !== 1'b1 || busy !== 1'b0)
      $display("FAIL err_resume_idle err=%b busy=%b want 1 0", err_pulse, busy); else n_pass++;
    send(OP_START, M_RSV, 4);
    n_checks++; if (err_pulse !== 1'b1 || busy !== 1'b0 || cnt_clr !== 1'b0)
      $display("FAIL err_rsvd_mode err=%b busy=%b clr=%b want 1 0 0", err_pulse, busy, cnt_clr); else n_pass++;
    @(negedge clk);
    n_checks++; if (err_pulse !== 1'b0 || busy !== 1'b0)
      $display("FAIL err_rsvd_after err=%b busy=%b want 0 0", err_pulse, busy); else n_pass++;
  endtask

  task automatic test_async_reset;
    send(OP_START, M_ONE, 10);
    @(negedge clk);
    for (int k = 0; k < 32 && cnt_val !== 4; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, cnt_hold, cnt_clr, cnt_up, cmd_ready} !== 5'b01011)
      $display("FAIL async_rst busy/hold/clr/up/ready=%b want 01011", {busy, cnt_hold, cnt_clr, cnt_up, cmd_ready}); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (cnt_val !== 4) $display("FAIL rst_keeps_cnt got %0d want 4", cnt_val); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    send(OP_START, M_ONE, 3);
    n_checks++; if (cnt_clr !== 1'b1) $display("FAIL restart_clr got %b want 1", cnt_clr); else n_pass++;
    @(negedge clk);
    for (int t = 1; t <= 4; t++) begin
      n_checks++; if (cnt_val !== W'(t - 1)) $display("FAIL restart_cnt t=%0d got %0d want %0d", t, cnt_val, t - 1); else n_pass++;
      @(negedge clk);
    end
    n_checks++; if (done_pulse !== 1'b1) $display("FAIL restart_done got %b want 1", done_pulse); else n_pass++;
  endtask

  task automatic test_random;
    exp_t e;
    int mode, lim, n;
    for (int it = 0; it < 8; it++) begin
      mode = $urandom_range(0, 2);
      lim  = $urandom_range(0, 6);
      n    = 3 * (lim + 2) + 4;
      send(OP_STOP, M_ONE, 0);
      send(OP_START, 2'(mode), W'(lim));
      for (int t = 0; t <= n; t++) begin
        e = model(mode, lim, t);
        n_checks++;
        if ({cnt_clr, busy, done_pulse, wrap_pulse, cnt_hold, cmd_ready} !==
            {e.clr, e.busy, e.done, e.wrap, e.hold, !e.clr})
          $display("FAIL rand_flags m=%0d L=%0d t=%0d clr/busy/done/wrap/hold/rdy=%b want %b", mode, lim, t,
                   {cnt_clr, busy, done_pulse, wrap_pulse, cnt_hold, cmd_ready},
                   {e.clr, e.busy, e.done, e.wrap, e.hold, !e.clr});
        else n_pass++;
        if (e.cnt_vld) begin
          n_checks++;
          if (cnt_val !== W'(e.cnt) || (e.up_vld && cnt_up !== e.up))
            $display("FAIL rand_cnt m=%0d L=%0d t=%0d cnt=%0d up=%b want %0d %b", mode, lim, t, cnt_val, cnt_up, e.cnt, e.up);
          else n_pass++;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_periodic;
    test_bounce;
    test_pause;
    test_same_cycle;
    test_errors;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
